spi_target: RTL and testbench
=============================

# spi_target

SPI target (responder) for the SoC's SPI master pins: an external or looped-back SPI initiator in mode 0 (CPOL=0, CPHA=0, MSB first, 8-bit frames) exchanges bytes with on-chip logic. The external `sclk`, `cs` and `mosi` pins are oversampled in the system clock domain. Received bytes go out on a valid/ready stream, and transmit bytes come in on a valid/ready stream. It sits beside the UART/SPI/QEI/PWM peripherals in the user project and connects to user IO pads.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `io_spi_clk`, `io_spi_cs`, `io_spi_mosi` (min 2).
- `FILL_BYTE`, 8'hFF: byte shifted out when no transmit data is available.
- `RX_FIFO_DEPTH`, 4: receive FIFO depth, power of two. Used only with `SPI_TARGET_RX_FIFO_EN`.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_spi_clk`  in  1  SPI clock from the initiator (async).
- `io_spi_cs`  in  1  chip select, active-low (async).
- `io_spi_mosi`  in  1  initiator data out (async).
- `io_spi_miso`  out  1  target data out.
- `io_spi_miso_oeb`  out  1  MISO output enable, active-low; 0 only while selected.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` valid.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `tx_data`  in  8  byte for the next frame.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmit holding register empty.
- `busy`  out  1  the synchronized `cs` is low.
- `rx_overrun`  out  1  one-cycle pulse: a completed byte was dropped because storage was full.
- `tx_underrun`  out  1  one-cycle pulse: `FILL_BYTE` was loaded instead of user data.
- `frame_err`  out  1  one-cycle pulse: `cs` deasserted with a partial byte.

## Operation
- Synchronize the inputs, then edge-detect against a one-flop delayed copy. Events are `cs_fall`, `cs_rise`, `sclk_rise` and `sclk_fall`.
- States: IDLE (`cs` high) and ACTIVE.
  - IDLE→ACTIVE on `cs_fall`.
  - ACTIVE→IDLE on `cs_rise`.
  - While IDLE, `sclk` and `mosi` activity is ignored.
- Load point:
  - Occurs on `cs_fall`, and on the `sclk_fall` that follows the 8th `sclk_rise` of a byte.
  - If the transmit holding register is full, copy it into the tx shift register and mark it empty.
  - Otherwise load `FILL_BYTE` and pulse `tx_underrun`.
  - `io_spi_miso` = shift register bit 7 from the load cycle onward.
- `sclk_rise`: shift the synchronized `mosi` into the rx shift register LSB and increment the 3-bit `bit_cnt`.
  - When `bit_cnt` wraps 7→0, the byte is complete and is pushed to rx storage.
- `sclk_fall` (not at a load point): shift the tx register left by 1, so `io_spi_miso` presents the next bit.
- Transmit holding register accepts on `tx_valid && tx_ready`. `tx_ready` = register empty.
  - If a write and a load point occur in the same cycle with the register empty, the load uses `FILL_BYTE` (underrun). The written byte is stored for the next frame.
- Rx storage (default): one holding register. `rx_valid` = full. Pop on `rx_valid && rx_ready`.
  - Push while full and not popping: the new byte is dropped and `rx_overrun` pulses.
  - Push and pop in the same cycle: the new byte replaces the old one; no overrun.
- `cs_rise` with `bit_cnt`≠0: discard the partial byte, pulse `frame_err`, clear `bit_cnt`.
- `cs_rise` with `bit_cnt`=0: clear `bit_cnt` only.
- The tx shift register contents are discarded at `cs_rise`. The holding register is untouched.
- `io_spi_miso_oeb` = 0 in ACTIVE, 1 in IDLE.

## Timing
- Reset values:
  - `io_spi_miso`=0, `io_spi_miso_oeb`=1.
  - `rx_data`=0, `rx_valid`=0.
  - `tx_ready`=1, `busy`=0.
  - All pulses 0; `bit_cnt`=0; state IDLE.
  - Synchronizers reset to `cs`=1, `sclk`=0.
- Reset mid-frame aborts immediately. Stored rx and tx bytes are lost. No pulses are generated on release.
- Pin edge to internal event: `SYNC_STAGES`+1 clocks.
  - Pin edge to `io_spi_miso` update: `SYNC_STAGES`+2 clocks.
  - 8th pin `sclk` rise to `rx_valid`: `SYNC_STAGES`+2 clocks.
- Initiator constraints:
  - `sclk` high and low times ≥ `SYNC_STAGES`+4 clocks.
  - `cs` fall to first `sclk` rise ≥ `SYNC_STAGES`+4 clocks.
  - Last `sclk` fall to `cs` rise ≥ 2 clocks.
- `rx_valid`/`rx_data` stay stable until accepted. `tx_ready` deasserts the cycle after acceptance.

## Configuration
- `SPI_TARGET_RX_FIFO_EN` defined:
  - Rx storage is an `RX_FIFO_DEPTH`-entry FIFO; `rx_valid` = not empty.
  - Overrun occurs only when the FIFO is full and not popped in the same cycle.
  - Simultaneous push and pop keeps the count unchanged.
- Undefined: the single holding register described above. `RX_FIFO_DEPTH` is ignored.

## Test plan
- Preload `tx_data`=8'hA5, then a 1-byte frame with MOSI=8'h3C and `rx_ready`=1 → MISO bits 1,0,1,0,0,1,0,1; `rx_data`=8'h3C with one `rx_valid` pulse; no error pulses.
- Nothing preloaded, 2-byte frame → MISO = 8'hFF, 8'hFF; `tx_underrun` pulses twice.
- `rx_ready`=0, 2-byte frame MOSI 8'h11, 8'h22:
  - Default build: `rx_data`=8'h11 and `rx_overrun` pulses once.
  - FIFO build: both bytes are held, with no overrun.
- Raise `cs` after 5 `sclk` rises → `frame_err` pulses once; no `rx_valid`. The next full frame receives its byte correctly.
- Assert `reset` (0) at bit 4 of a frame with `rx_valid` high, then release → all outputs at reset values; `io_spi_miso_oeb`=1 until the next `cs` fall.
- Toggle `sclk` with `cs` high → no rx pushes, `io_spi_miso_oeb`=1, `bit_cnt` stays 0.

Source files
------------

// File: rtl/spi_target_if.sv
// Byte streams between the SPI target and on-chip logic: received bytes
// flow out on rx_*, bytes for the next frame flow in on tx_*.
interface spi_target_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled pins and valid/ready byte streams.
// Define SPI_TARGET_RX_FIFO_EN to replace the rx holding register with a FIFO.
module spi_target #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] FILL_BYTE     = 8'hFF,
    parameter int         RX_FIFO_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_spi_clk,
    input  logic          io_spi_cs,
    input  logic          io_spi_mosi,
    output logic          io_spi_miso,
    output logic          io_spi_miso_oeb,
    spi_target_if.slave   strm,
    output logic          busy,
    output logic          rx_overrun,
    output logic          tx_underrun,
    output logic          frame_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RX_FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_t      state, state_nxt;
    logic        load, rise_act, shift_act, end_act;
    logic [2:0]  bit_cnt;
    logic        load_pend;
    logic        rx_push_p1;
    logic [7:0]  rx_sh;
    logic [7:0]  tx_sh;
    logic [7:0]  tx_hold;
    logic        tx_full;
    logic        tx_wr;
    logic        miso_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_pop;

    // Input synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], io_spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], io_spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rise_act  = 1'b0;
        shift_act = 1'b0;
        end_act   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = ACTIVE;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                rise_act  = sclk_rise;
                load      = sclk_fall & load_pend;
                shift_act = sclk_fall & ~load_pend;
                if (cs_rise) begin
                    state_nxt = IDLE;
                    end_act   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_wr = strm.tx_valid & ~tx_full;

    // Bit engine: load_pend marks that the next sclk fall starts a new byte
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= 3'd0;
            load_pend   <= 1'b0;
            rx_push_p1  <= 1'b0;
            tx_sh       <= 8'd0;
            tx_full     <= 1'b0;
            miso_q      <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            tx_underrun <= load & ~tx_full;
            frame_err   <= end_act & (bit_cnt != 3'd0);
            rx_push_p1  <= rise_act & (bit_cnt == 3'd7);
            miso_q      <= tx_sh[7];
            tx_full     <= (tx_full & ~load) | tx_wr;
            if (end_act) begin
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                tx_sh     <= 8'd0;
            end else begin
                if (rise_act) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) load_pend <= 1'b1;
                end
                if (load) begin
                    tx_sh     <= tx_full ? tx_hold : FILL_BYTE;
                    load_pend <= 1'b0;
                end else if (shift_act) begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rise_act) rx_sh <= {rx_sh[6:0], mosi_s};
        if (tx_wr)    tx_hold <= strm.tx_data;
    end

    assign rx_pop = rx_valid_q & strm.rx_ready;

`ifdef SPI_TARGET_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;
    logic          fifo_full;
    logic          push_ok;

    assign fifo_full  = (cnt == (PW+1)'(RX_FIFO_DEPTH));
    assign push_ok    = rx_push_p1 & (~fifo_full | rx_pop);
    assign rx_valid_q = (cnt != '0);
    assign rx_data_q  = mem[rd_ptr];

    // Full FIFO still accepts a byte when the head leaves in the same cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push_p1 & fifo_full & ~rx_pop;
            if (push_ok) begin
                mem[wr_ptr] <= rx_sh;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rx_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, rx_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign rx_valid_q = rx_full;
    assign rx_data_q  = rx_hold;

    // A push that coincides with a pop overwrites the departing byte
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_hold    <= 8'd0;
            rx_full    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push_p1 & rx_full & ~rx_pop;
            if (rx_push_p1 && (!rx_full || rx_pop)) begin
                rx_hold <= rx_sh;
                rx_full <= 1'b1;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end
`endif

    assign strm.rx_data    = rx_data_q;
    assign strm.rx_valid   = rx_valid_q;
    assign strm.tx_ready   = ~tx_full;
    assign io_spi_miso     = miso_q;
    assign io_spi_miso_oeb = (state != ACTIVE);
    assign busy            = ~cs_s;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: drivers push expected rx bytes and MISO
// bits into queues; monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_spi_target;

    localparam int HALF = 8;

    logic clock;
    logic reset;
    bit   sclk;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oeb;
    logic busy;
    logic rx_overrun;
    logic tx_underrun;
    logic frame_err;

    spi_target_if bus ();

    spi_target dut (
        .clock           (clock),
        .reset           (reset),
        .io_spi_clk      (sclk),
        .io_spi_cs       (cs),
        .io_spi_mosi     (mosi),
        .io_spi_miso     (miso),
        .io_spi_miso_oeb (miso_oeb),
        .strm            (bus),
        .busy            (busy),
        .rx_overrun      (rx_overrun),
        .tx_underrun     (tx_underrun),
        .frame_err       (frame_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_under = 0;
    int cnt_over  = 0;
    int cnt_ferr  = 0;
    int snap_under = 0;
    bit miso_chk = 1'b0;

    logic [7:0] exp_rx[$];
    bit         exp_miso[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Rx stream monitor and error-pulse counters
    always @(negedge clock) begin
        if (reset) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h, expected no byte", bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, exp_rx.pop_front());
                end
            end
            if (tx_underrun) cnt_under++;
            if (rx_overrun)  cnt_over++;
            if (frame_err)   cnt_ferr++;
        end
    end

    // MISO monitor: the initiator samples at its own sclk rise
    always @(posedge sclk) begin
        if (miso_chk) begin
            if (exp_miso.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL miso_unexpected: got %0b, expected no bit", miso);
            end else begin
                check("miso", miso, exp_miso.pop_front());
            end
            check("miso_oeb_active", miso_oeb, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clock);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        check("tx_ready_after_write", bus.tx_ready, 1'b0);
    endtask

    task automatic cs_low();
        @(negedge clock);
        cs = 1'b0;
        clocks(HALF);
    endtask

    task automatic cs_high();
        clocks(4);
        cs = 1'b1;
        clocks(12);
    endtask

    // Shift nbits MSB first; snap records underrun count before the final fall
    task automatic spi_xfer(input logic [7:0] mo, input logic [7:0] mi,
                            input int nbits, input bit snap);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            if (miso_chk) exp_miso.push_back(mi[i]);
            clocks(HALF);
            sclk = 1'b1;
            clocks(HALF);
            if (snap && i == 0) snap_under = cnt_under;
            sclk = 1'b0;
        end
        clocks(2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_rx.size() != 0; i++) @(negedge clock);
        check("rx_drained", exp_rx.size(), 0);
    endtask

    int u0, o0, f0;

    initial begin
        reset        = 1'b0;
        cs           = 1'b1;
        mosi         = 1'b0;
        bus.rx_ready = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        clocks(3);
        check("rst_miso",     miso, 1'b0);
        check("rst_miso_oeb", miso_oeb, 1'b1);
        check("rst_rx_data",  bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_busy",     busy, 1'b0);
        check("rst_pulses",   {rx_overrun, tx_underrun, frame_err}, 3'b000);
        reset = 1'b1;
        clocks(4);

        // Preloaded byte, single frame
        bus.rx_ready = 1'b1;
        u0 = cnt_under; o0 = cnt_over; f0 = cnt_ferr;
        tx_write(8'hA5);
        exp_rx.push_back(8'h3C);
        miso_chk = 1'b1;
        cs_low();
        check("busy_active", busy, 1'b1);
        spi_xfer(8'h3C, 8'hA5, 8, 1'b1);
        miso_chk = 1'b0;
        cs_high();
        wait_drain();
        check("t1_underrun", snap_under - u0, 0);
        check("t1_overrun",  cnt_over - o0, 0);
        check("t1_frame_err", cnt_ferr - f0, 0);
        check("t1_oeb_idle", miso_oeb, 1'b1);

        // Nothing preloaded, two bytes of fill
        u0 = cnt_under;
        exp_rx.push_back(8'h81);
        exp_rx.push_back(8'h7E);
        miso_chk = 1'b1;
        cs_low();
        spi_xfer(8'h81, 8'hFF, 8, 1'b0);
        spi_xfer(8'h7E, 8'hFF, 8, 1'b1);
        miso_chk = 1'b0;
        cs_high();
        wait_drain();
        check("t2_underrun", snap_under - u0, 2);

        // Consumer stalled across a two-byte frame
        bus.rx_ready = 1'b0;
        o0 = cnt_over;
        cs_low();
        spi_xfer(8'h11, 8'hFF, 8, 1'b0);
        spi_xfer(8'h22, 8'hFF, 8, 1'b0);
        cs_high();
        check("t3_rx_valid", bus.rx_valid, 1'b1);
        check("t3_rx_data",  bus.rx_data, 8'h11);
`ifdef SPI_TARGET_RX_FIFO_EN
        check("t3_overrun", cnt_over - o0, 0);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
`else
        check("t3_overrun", cnt_over - o0, 1);
        exp_rx.push_back(8'h11);
`endif
        bus.rx_ready = 1'b1;
        wait_drain();

        // Partial frame then a good one
        f0 = cnt_ferr;
        cs_low();
        spi_xfer(8'hF0, 8'hFF, 5, 1'b0);
        cs_high();
        check("t4_frame_err", cnt_ferr - f0, 1);
        check("t4_no_rx", bus.rx_valid, 1'b0);
        tx_write(8'h96);
        exp_rx.push_back(8'hC3);
        miso_chk = 1'b1;
        cs_low();
        spi_xfer(8'hC3, 8'h96, 8, 1'b0);
        miso_chk = 1'b0;
        cs_high();
        wait_drain();
        check("t4_frame_err_after", cnt_ferr - f0, 1);

        // Reset in the middle of a frame with a byte held
        bus.rx_ready = 1'b0;
        cs_low();
        spi_xfer(8'h5A, 8'hFF, 8, 1'b0);
        tx_write(8'h33);
        spi_xfer(8'h00, 8'hFF, 4, 1'b0);
        check("t5_rx_valid_before", bus.rx_valid, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        u0 = cnt_under; o0 = cnt_over; f0 = cnt_ferr;
        #1;
        check("t5_miso",     miso, 1'b0);
        check("t5_miso_oeb", miso_oeb, 1'b1);
        check("t5_rx_data",  bus.rx_data, 8'h00);
        check("t5_rx_valid", bus.rx_valid, 1'b0);
        check("t5_tx_ready", bus.tx_ready, 1'b1);
        check("t5_busy",     busy, 1'b0);
        cs = 1'b1;
        clocks(3);
        reset = 1'b1;
        bus.rx_ready = 1'b1;
        clocks(12);
        check("t5_oeb_after", miso_oeb, 1'b1);
        check("t5_no_pulses", (cnt_under - u0) + (cnt_over - o0) + (cnt_ferr - f0), 0);

        // sclk and mosi activity while deselected
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            clocks(HALF);
            sclk = 1'b1;
            clocks(HALF);
            sclk = 1'b0;
            if (i == 5) check("t6_oeb_mid", miso_oeb, 1'b1);
        end
        clocks(6);
        check("t6_oeb",     miso_oeb, 1'b1);
        check("t6_bit_cnt", dut.bit_cnt, 3'd0);
        check("t6_rx_valid", bus.rx_valid, 1'b0);
        exp_rx.push_back(8'h69);
        cs_low();
        spi_xfer(8'h69, 8'hFF, 8, 1'b0);
        cs_high();
        wait_drain();
        check("miso_queue_empty", exp_miso.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
